// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start bit, D0..D7 LSB first,
// optional parity and 1 or 2 stop bits, each held CLK_PER_BIT cycles on a registered tx_o.
module uart_tx #(
   parameter int unsigned CLK_PER_BIT = 4,
   parameter int unsigned PARITY_EN   = 0,
   parameter int unsigned PARITY_ODD  = 0,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o
);

   localparam int unsigned       BAUD_W         = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST      = BAUD_W'(CLK_PER_BIT - 1);
   localparam logic [2:0]        STOP_LAST      = 3'(STOP_BITS - 1);
   localparam logic              PARITY_ODD_BIT = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [BAUD_W-1:0] baud_d;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              parity_q;
   logic              tx_q;
   logic              ready_q;
   logic              busy_q;
   logic              bit_end;

   // A serial bit ends on the last baud cycle; the counter then wraps to zero.
   assign bit_end = (baud_q == BAUD_LAST);
   assign baud_d  = bit_end ? '0 : baud_q + 1'b1;

   // NOTE: every register here is assigned with <= so all branches see the pre-edge values;
   // the data shift register and parity latch are reset too, so no X ever reaches tx_o.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               baud_q  <= '0;
               bit_q   <= '0;
               if (valid_i && ready_q) begin
                  shift_q  <= data_i;
                  parity_q <= (^data_i) ^ PARITY_ODD_BIT;
                  state_q  <= S_START;
                  tx_q     <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end

            S_START: begin
               baud_q <= baud_d;
               if (bit_end) begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
               end
            end

            S_DATA: begin
               baud_q <= baud_d;
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
                     bit_q <= '0;
                     if (PARITY_EN != 0) begin
                        state_q <= S_PARITY;
                        tx_q    <= parity_q;
                     end else begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end
            end

            S_PARITY: begin
               baud_q <= baud_d;
               if (bit_end) begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
               end
            end

            S_STOP: begin
               baud_q <= baud_d;
               if (bit_end) begin
                  if (bit_q == STOP_LAST) begin
                     state_q <= S_IDLE;
                     bit_q   <= '0;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
               baud_q  <= '0;
               bit_q   <= '0;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_o    = tx_q;
   assign ready_o = ready_q;
   assign busy_o  = busy_q;

endmodule
